// File: rtl/serial_subtract_if.sv
// Operand/result bundle for serial_subtract. The overflow flag exists only when
// SERIAL_SUBTRACT_OVERFLOW_EN is defined.
interface serial_subtract_if #(
    parameter int WIDTH = 8
);
    // start is a single-cycle request, taken only while the block is not shifting.
    // busy/done are status outputs; diff and its flags hold until the next done.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;
    logic [1:0]       fsm_state;
`ifdef SERIAL_SUBTRACT_OVERFLOW_EN
    logic             overflow;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out, zero, fsm_state, overflow
    );
    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out, zero, fsm_state, overflow
    );
`else
    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out, zero, fsm_state
    );
    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out, zero, fsm_state
    );
`endif
endinterface

// File: rtl/serial_subtract.sv
// Bit-serial a - b - borrow_in, one bit per clock LSB first, with a borrow flip-flop.
// Optional signed-overflow flag via SERIAL_SUBTRACT_OVERFLOW_EN.
module serial_subtract #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic            clk,
    input logic            reset,
    serial_subtract_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] sh_a_q, sh_b_q, res_q;
    logic             br_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q, borrow_out_q, zero_q;
    logic [WIDTH-1:0] diff_q;

    logic             bit_d, br_d;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        bit_d = sh_a_q[0] ^ sh_b_q[0] ^ br_q;
        br_d  = (~sh_a_q[0] & sh_b_q[0]) | (~(sh_a_q[0] ^ sh_b_q[0]) & br_q);
        res_d = {bit_d, res_q[WIDTH-1:1]};
    end

`ifdef SERIAL_SUBTRACT_OVERFLOW_EN
    // Original operand MSBs are gone after shifting, so keep them for the overflow test.
    logic a_msb_q, b_msb_q, overflow_q;
    assign bus.overflow = overflow_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sh_a_q       <= '0;
            sh_b_q       <= '0;
            res_q        <= '0;
            br_q         <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b0;
`ifdef SERIAL_SUBTRACT_OVERFLOW_EN
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            overflow_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        sh_a_q  <= bus.a;
                        sh_b_q  <= bus.b;
                        br_q    <= bus.borrow_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
`ifdef SERIAL_SUBTRACT_OVERFLOW_EN
                        a_msb_q <= bus.a[WIDTH-1];
                        b_msb_q <= bus.b[WIDTH-1];
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    sh_a_q <= sh_a_q >> 1;
                    sh_b_q <= sh_b_q >> 1;
                    br_q   <= br_d;
                    res_q  <= res_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        diff_q       <= res_d;
                        borrow_out_q <= br_d;
                        zero_q       <= (res_d == '0);
`ifdef SERIAL_SUBTRACT_OVERFLOW_EN
                        overflow_q   <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.zero       = zero_q;
    assign bus.fsm_state  = state_q;

endmodule

// File: tb/tb_serial_subtract.sv
// Bench for serial_subtract: WIDTH=8 and WIDTH=2 instances checked against an
// arithmetic reference (a - b - borrow_in taken modulo 2^(WIDTH+1)).
module tb_serial_subtract;

  logic clk = 1'b0;
  logic reset;

  serial_subtract_if #(.WIDTH(8)) i8 ();
  serial_subtract_if #(.WIDTH(2)) i2 ();

  serial_subtract #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .bus(i8));
  serial_subtract #(.WIDTH(2)) u2 (.clk(clk), .reset(reset), .bus(i2));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [64:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       z;
    logic       ov;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: {borrow_out, diff} as the (w+1)-bit two's complement of a - b - bin.
  function automatic logic [64:0] ref_sub(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic bin);
    logic [64:0] full;
    logic [64:0] mask;
    full = {1'b0, a} - {1'b0, b} - {64'd0, bin};
    mask = (65'd1 << (w + 1)) - 65'd1;
    return full & mask;
  endfunction

  function automatic logic ref_ov(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic [63:0] d);
    return (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
  endfunction

  function automatic logic done_of(input int w);
    return (w == 8) ? i8.done : i2.done;
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a negedge. Returns at the negedge where done is seen,
  // lat = number of rising edges from acceptance to done.
  task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b, input logic bin,
                        output int lat, output logic [63:0] d, output logic bo, output logic z,
                        output logic bsy, output logic ov);
    if (w == 8) begin
      i8.a = a[7:0]; i8.b = b[7:0]; i8.borrow_in = bin; i8.start = 1'b1;
    end else begin
      i2.a = a[1:0]; i2.b = b[1:0]; i2.borrow_in = bin; i2.start = 1'b1;
    end
    @(negedge clk);
    i8.start = 1'b0;
    i2.start = 1'b0;
    lat = 0;
    while (!done_of(w) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    ov = 1'b0;
    if (w == 8) begin
      d = {56'd0, i8.diff}; bo = i8.borrow_out; z = i8.zero; bsy = i8.busy;
`ifdef SERIAL_SUBTRACT_OVERFLOW_EN
      ov = i8.overflow;
`endif
    end else begin
      d = {62'd0, i2.diff}; bo = i2.borrow_out; z = i2.zero; bsy = i2.busy;
`ifdef SERIAL_SUBTRACT_OVERFLOW_EN
      ov = i2.overflow;
`endif
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    logic [63:0] d;
    logic bo, z, bsy, ov;
    logic [64:0] e;
    int pulses;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h2A, 8'h2A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.borrow_in = 1'b0;
    i2.start = 1'b0; i2.a = '0; i2.b = '0; i2.borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_busy", {63'd0, i8.busy}, 64'd0);
    check("rst_done", {63'd0, i8.done}, 64'd0);
    check("rst_diff", {56'd0, i8.diff}, 64'd0);
    check("rst_borrow", {63'd0, i8.borrow_out}, 64'd0);
    check("rst_zero", {63'd0, i8.zero}, 64'd0);
    @(negedge clk);

    // Table vectors, each followed by a one-cycle-pulse check
    for (int i = 0; i < 9; i++) begin
      run_op(8, {56'd0, tbl[i].a}, {56'd0, tbl[i].b}, tbl[i].bin, lat, d, bo, z, bsy, ov);
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd8);
      check($sformatf("tbl%0d_diff", i), d, {56'd0, tbl[i].d});
      check($sformatf("tbl%0d_borrow", i), {63'd0, bo}, {63'd0, tbl[i].bo});
      check($sformatf("tbl%0d_zero", i), {63'd0, z}, {63'd0, tbl[i].z});
      check($sformatf("tbl%0d_busy_at_done", i), {63'd0, bsy}, 64'd0);
`ifdef SERIAL_SUBTRACT_OVERFLOW_EN
      check($sformatf("tbl%0d_overflow", i), {63'd0, ov}, {63'd0, tbl[i].ov});
`endif
      @(negedge clk);
      check($sformatf("tbl%0d_done_width", i), {63'd0, i8.done}, 64'd0);
      check($sformatf("tbl%0d_diff_held", i), {56'd0, i8.diff}, {56'd0, tbl[i].d});
    end

    // Back-to-back: second start issued in the DONE cycle of the first
    run_op(8, 64'h00, 64'h01, 1'b0, lat, d, bo, z, bsy, ov);
    check("b2b_first_diff", d, 64'hFF);
    run_op(8, 64'h01, 64'h01, 1'b1, lat, d, bo, z, bsy, ov);
    check("b2b_latency", 64'(lat), 64'd8);
    check("b2b_diff", d, 64'hFF);
    check("b2b_borrow", {63'd0, bo}, 64'd1);
    @(negedge clk);

    // Start pulsed during SHIFT is ignored; exactly one done pulse
    i8.a = 8'h2A; i8.b = 8'h2A; i8.borrow_in = 1'b0; i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    @(negedge clk);
    check("ign_busy", {63'd0, i8.busy}, 64'd1);
    check("ign_diff_held", {56'd0, i8.diff}, 64'hFF);
    i8.a = 8'h01; i8.b = 8'h00; i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 14; c++) begin
      if (i8.done) begin
        pulses++;
        check("ign_diff", {56'd0, i8.diff}, 64'h00);
        check("ign_zero", {63'd0, i8.zero}, 64'd1);
      end
      @(negedge clk);
    end
    check("ign_done_pulses", 64'(pulses), 64'd1);

    // Reset during the 4th SHIFT cycle aborts without a done pulse
    run_op(8, 64'h05, 64'h03, 1'b0, lat, d, bo, z, bsy, ov);
    @(negedge clk);
    i8.a = 8'h55; i8.b = 8'h11; i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {63'd0, i8.busy}, 64'd0);
    check("abort_done", {63'd0, i8.done}, 64'd0);
    check("abort_diff", {56'd0, i8.diff}, 64'd0);
    check("abort_borrow", {63'd0, i8.borrow_out}, 64'd0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (i8.done) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    run_op(8, 64'h55, 64'h11, 1'b0, lat, d, bo, z, bsy, ov);
    check("after_abort_latency", 64'(lat), 64'd8);
    check("after_abort_diff", d, 64'h44);
    @(negedge clk);

    // Randomized operations against the arithmetic reference
    for (int n = 0; n < 40; n++) begin
      logic [63:0] ra, rb;
      logic rbin;
      ra = 64'($urandom_range(0, 255));
      rb = 64'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_sub(8, ra, rb, rbin));
      run_op(8, ra, rb, rbin, lat, d, bo, z, bsy, ov);
      e = exp_q.pop_front();
      check($sformatf("rnd%0d_latency", n), 64'(lat), 64'd8);
      check($sformatf("rnd%0d_result a=%0h b=%0h bin=%0b", n, ra, rb, rbin),
            {55'd0, bo, d[7:0]}, e[63:0]);
      check($sformatf("rnd%0d_zero", n), {63'd0, z}, {63'd0, (e[7:0] == 8'd0)});
`ifdef SERIAL_SUBTRACT_OVERFLOW_EN
      check($sformatf("rnd%0d_overflow", n), {63'd0, ov}, {63'd0, ref_ov(8, ra, rb, e[63:0])});
`endif
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // WIDTH=2 exhaustive sweep
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          exp_q.push_back(ref_sub(2, 64'(ia), 64'(ib), 1'(ic)));
          run_op(2, 64'(ia), 64'(ib), 1'(ic), lat, d, bo, z, bsy, ov);
          e = exp_q.pop_front();
          check($sformatf("w2_latency a=%0d b=%0d bin=%0d", ia, ib, ic), 64'(lat), 64'd2);
          check($sformatf("w2_result a=%0d b=%0d bin=%0d", ia, ib, ic),
                {61'd0, bo, d[1:0]}, e[63:0]);
          check($sformatf("w2_zero a=%0d b=%0d bin=%0d", ia, ib, ic),
                {63'd0, z}, {63'd0, (e[1:0] == 2'd0)});
`ifdef SERIAL_SUBTRACT_OVERFLOW_EN
          check($sformatf("w2_overflow a=%0d b=%0d bin=%0d", ia, ib, ic),
                {63'd0, ov}, {63'd0, ref_ov(2, 64'(ia), 64'(ib), e[63:0])});
`endif
          @(negedge clk);
        end
      end
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
